// File: rtl/seq_multiplier_ctrl.sv
// Shift-and-add unsigned multiplier controller: one add/shift iteration per
// clock on a single 2*WIDTH-bit adder, fixed WIDTH-cycle latency, done strobe.
module seq_multiplier_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mc;
  logic [WIDTH-1:0] mp;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             iterate;
  logic             last_iter;
  logic [PW-1:0]    acc_step;

  // The one shared adder: partial product is added only when the current
  // multiplier bit is set. Operands are bounded so the sum never overflows PW.
  assign acc_step  = mp[0] ? (acc + mc) : acc;
  assign last_iter = (cnt == LAST_ITER);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy    = 1'b1;
        iterate = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // NOTE: the datapath registers are plain flops (no memory array), so they
  // are all cleared by reset to give an aborted operation a clean restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      mc  <= '0;
      mp  <= '0;
      cnt <= '0;
      P   <= '0;
    end else if (accept) begin
      acc <= '0;
      mc  <= {{WIDTH{1'b0}}, A};
      mp  <= B;
      cnt <= '0;
    end else if (iterate) begin
      acc <= acc_step;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt + 1'b1;
      // Product register captures the final sum, including this iteration's add.
      if (last_iter) P <= acc_step;
    end
  end

endmodule
